// File: rtl/acc_peak_search.sv
// Per-frame peak search, frame sum and threshold detect over a streamed power vector.
// Latency: results and dout_valid register one cycle after the last bin is accepted.
// Backpressure: none; accepts a sample on every din_valid, gaps allowed anywhere.
module acc_peak_search #(
    parameter int DIN_WIDTH  = 64,
    parameter int VECTOR_LEN = 64,
    parameter int IDX_WIDTH  = $clog2(VECTOR_LEN),
    parameter int SUM_WIDTH  = DIN_WIDTH + $clog2(VECTOR_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    input  logic [DIN_WIDTH-1:0] threshold,
    output logic [DIN_WIDTH-1:0] peak_val,
    output logic [IDX_WIDTH-1:0] peak_idx,
    output logic [SUM_WIDTH-1:0] frame_sum,
    output logic                 detect,
    output logic                 dout_valid,
    output logic                 frame_err
);

    localparam logic [IDX_WIDTH-1:0] LAST_BIN = IDX_WIDTH'(VECTOR_LEN - 1);
    localparam logic [IDX_WIDTH-1:0] ONE_BIN  = IDX_WIDTH'(1);

    // running state of the frame in progress
    logic [IDX_WIDTH-1:0] r_bin;
    logic [DIN_WIDTH-1:0] r_cur_max;
    logic [IDX_WIDTH-1:0] r_cur_idx;
    logic [SUM_WIDTH-1:0] r_cur_sum;

    // reported results of the last completed frame
    logic [DIN_WIDTH-1:0] r_peak_val;
    logic [IDX_WIDTH-1:0] r_peak_idx;
    logic [SUM_WIDTH-1:0] r_frame_sum;
    logic                 r_detect;
    logic                 r_dout_valid;
    logic                 r_frame_err;

    logic                 w_start;
    logic                 w_err;
    logic                 w_last;
    logic                 w_gt;
    logic [SUM_WIDTH-1:0] w_din_ext;
    logic [DIN_WIDTH-1:0] w_nxt_max;
    logic [IDX_WIDTH-1:0] w_nxt_idx;
    logic [SUM_WIDTH-1:0] w_nxt_sum;
    logic [IDX_WIDTH-1:0] w_nxt_bin;

    // A sync sample always starts a new frame; if it lands mid-frame the partial
    // frame is dropped and flagged. Sync on the would-be last bin also suppresses the report.
    assign w_start   = frame_sync || (r_bin == '0);
    assign w_err     = din_valid && frame_sync && (r_bin != '0);
    assign w_last    = din_valid && !frame_sync && (r_bin == LAST_BIN);

    // Strict compare so ties keep the earliest bin.
    assign w_gt      = din > r_cur_max;
    assign w_din_ext = SUM_WIDTH'(din);
    assign w_nxt_max = (w_start || w_gt) ? din : r_cur_max;
    assign w_nxt_idx = w_start ? '0 : (w_gt ? r_bin : r_cur_idx);
    assign w_nxt_sum = w_start ? w_din_ext : (r_cur_sum + w_din_ext);
    // Power-of-two length: the counter wraps naturally from LAST_BIN to 0.
    assign w_nxt_bin = frame_sync ? ONE_BIN : (r_bin + ONE_BIN);

    // bin counter and running max/idx/sum, advanced only on accepted samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin     <= '0;
            r_cur_max <= '0;
            r_cur_idx <= '0;
            r_cur_sum <= '0;
        end else if (din_valid) begin
            r_bin     <= w_nxt_bin;
            r_cur_max <= w_nxt_max;
            r_cur_idx <= w_nxt_idx;
            r_cur_sum <= w_nxt_sum;
        end
    end

    // report registers: load on the last bin, hold otherwise; status flags pulse for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_peak_val   <= '0;
            r_peak_idx   <= '0;
            r_frame_sum  <= '0;
            r_detect     <= 1'b0;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_dout_valid <= w_last;
            r_frame_err  <= w_err;
            if (w_last) begin
                r_peak_val  <= w_nxt_max;
                r_peak_idx  <= w_nxt_idx;
                r_frame_sum <= w_nxt_sum;
                r_detect    <= (w_nxt_max > threshold);
            end
        end
    end

    assign peak_val   = r_peak_val;
    assign peak_idx   = r_peak_idx;
    assign frame_sum  = r_frame_sum;
    assign detect     = r_detect;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;

endmodule
